// File: rtl/pc_contador_pkg.sv
// pc_contador_pkg
//   Shared definitions for the ones-counter control unit:
//   - state_t       : controller state encoding
//   - WIDTH_DEFAULT : default datapath operand width
//   - wdWidth()     : bit width of the iteration watchdog for a given operand width
package pc_contador_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    INC,
    SHIFT,
    DONE
  } state_t;

  // The watchdog must hold WIDTH+1 (the trip value), so it needs
  // enough bits for values 0..WIDTH+1.
  function automatic int unsigned wdWidth(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/pc_contador_if.sv
// pc_contador_if
//   Bundles the controller's handshake and datapath control/status lines.
//   Handshake : start (request), busy, done, err
//   Datapath  : zeroA, zeroA0 (status in), LoadA, RstB, IncB, ShiftR (controls out)
//   modport slave  : seen by the control unit
//   modport master : seen by the surrounding logic / datapath side
interface pc_contador_if;

  logic start;
  logic zeroA;
  logic zeroA0;
  logic LoadA;
  logic RstB;
  logic IncB;
  logic ShiftR;
  logic busy;
  logic done;
  logic err;

  modport slave (
    input  start, zeroA, zeroA0,
    output LoadA, RstB, IncB, ShiftR, busy, done, err
  );

  modport master (
    output start, zeroA, zeroA0,
    input  LoadA, RstB, IncB, ShiftR, busy, done, err
  );

endinterface

// File: rtl/pc_contador.sv
// pc_contador
//   Control unit for the ones-counter datapath. Sequences load, test,
//   increment and shift so the datapath counts the set bits of its operand.
//
//   Ports:
//     clk    : single clock, rising edge
//     reset  : synchronous, active-low
//     bus    : pc_contador_if.slave
//                start  in  - level request, four-phase with done
//                zeroA  in  - operand register is all zero
//                zeroA0 in  - operand register bit 0
//                LoadA  out - load operand register
//                RstB   out - clear bit counter (asynchronous clear in the
//                             datapath, hence driven straight from a flop)
//                IncB   out - increment bit counter
//                ShiftR out - logical right shift of operand register
//                busy   out - LOAD/TEST/INC/SHIFT in progress
//                done   out - result valid
//                err    out - watchdog tripped, qualifies done
//
//   Every output is a flop loaded from the next-state decode, so outputs are
//   glitch-free and there is no combinational path from input to output.
module pc_contador
  import pc_contador_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  pc_contador_if.slave    bus
);

  localparam int unsigned WDW = wdWidth(WIDTH);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(WIDTH + 1);

  state_t         state;
  state_t         nextState;
  logic [WDW-1:0] wdCount;
  logic [WDW-1:0] wdNext;
  logic           wdTrip;

  logic loadAQ, rstBQ, incBQ, shiftRQ, busyQ, doneQ, errQ;
  logic loadANext, rstBNext, incBNext, shiftRNext, busyNext, doneNext, errNext;

  // The TEST visit being evaluated is counted, so the trip compares the
  // post-increment value: the (WIDTH+1)-th visit without zeroA trips.
  assign wdNext = wdCount + 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    wdTrip    = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) nextState = LOAD;
      LOAD:  nextState = TEST;
      TEST: begin
        if (bus.zeroA) begin
          nextState = DONE;
        end else if (wdNext == WD_LIMIT) begin
          nextState = DONE;
          wdTrip    = 1'b1;
        end else if (bus.zeroA0) begin
          nextState = INC;
        end else begin
          nextState = SHIFT;
        end
      end
      INC:   nextState = SHIFT;
      SHIFT: nextState = TEST;
      DONE:  if (!bus.start) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (from next state, registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    loadANext  = (nextState == LOAD);
    rstBNext   = (nextState == LOAD);
    incBNext   = (nextState == INC);
    shiftRNext = (nextState == SHIFT);
    busyNext   = (nextState inside {LOAD, TEST, INC, SHIFT});
    doneNext   = (nextState == DONE);
    // err is set by the tripping TEST and held only while DONE persists;
    // any other state (including LOAD) drops it.
    errNext    = (nextState == DONE) && (wdTrip || ((state == DONE) && errQ));
  end

  // ---------------------------------------------------------------------------
  // Output flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      loadAQ  <= 1'b0;
      rstBQ   <= 1'b0;
      incBQ   <= 1'b0;
      shiftRQ <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      loadAQ  <= loadANext;
      rstBQ   <= rstBNext;
      incBQ   <= incBNext;
      shiftRQ <= shiftRNext;
      busyQ   <= busyNext;
      doneQ   <= doneNext;
      errQ    <= errNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration watchdog: cleared in LOAD, counts TEST visits.
  // Cannot wrap because TEST exits at WIDTH+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdCount <= '0;
    end else if (state == LOAD) begin
      wdCount <= '0;
    end else if (state == TEST) begin
      wdCount <= wdNext;
    end
  end

  assign bus.LoadA  = loadAQ;
  assign bus.RstB   = rstBQ;
  assign bus.IncB   = incBQ;
  assign bus.ShiftR = shiftRQ;
  assign bus.busy   = busyQ;
  assign bus.done   = doneQ;
  assign bus.err    = errQ;

endmodule

// File: tb/tb_pc_contador.sv
// tb_pc_contador
//   Drives pc_contador beside a behavioural ones-counter datapath and checks
//   every cycle's outputs against a per-operation expected schedule, plus
//   literal done-cycle / pulse-count / result expectations.
module tb_pc_contador;
  import pc_contador_pkg::*;

  localparam int unsigned W = 16;

  typedef logic [6:0] vec_t; // {LoadA,RstB,IncB,ShiftR,busy,done,err}
  localparam vec_t V_LOAD  = 7'b1100100;
  localparam vec_t V_TEST  = 7'b0000100;
  localparam vec_t V_INC   = 7'b0010100;
  localparam vec_t V_SHIFT = 7'b0001100;
  localparam vec_t V_DONE  = 7'b0000010;
  localparam vec_t V_ERR   = 7'b0000011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_contador_if bus();

  pc_contador #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- behavioural datapath ----------------
  logic [15:0] operand;
  logic [15:0] regA;
  logic [4:0]  regB;
  logic        stub;

  always @(posedge clk) begin
    if (bus.LoadA)       regA <= operand;
    else if (bus.ShiftR) regA <= regA >> 1;
    if (bus.RstB)        regB <= '0;
    else if (bus.IncB)   regB <= regB + 5'd1;
  end

  assign bus.zeroA  = stub ? 1'b0 : (regA == 16'h0000);
  assign bus.zeroA0 = stub ? 1'b0 : regA[0];

  // ---------------- counters ----------------
  int nChecks = 0;
  int nErr    = 0;
  logic checkEn = 1'b0;

  task automatic check(input string name, input int act, input int req);
    nChecks++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic vec_t outVec();
    return {bus.LoadA, bus.RstB, bus.IncB, bus.ShiftR, bus.busy, bus.done, bus.err};
  endfunction

  // ---------------- reference model ----------------
  // An operation is: load, then for each bit up to the highest set bit a
  // test, an increment if the bit is set, and a shift; then a final test
  // that sees the operand empty, then done. A stuck-nonzero operand never
  // empties: WIDTH+1 tests then done with err.
  vec_t plan[$];
  vec_t expV = '0;
  logic mDone = 1'b0;

  task automatic buildPlan(input logic [15:0] op, input logic stuck);
    int k;
    plan.push_back(V_LOAD);
    if (stuck) begin
      for (int i = 0; i < int'(W); i++) begin
        plan.push_back(V_TEST);
        plan.push_back(V_SHIFT);
      end
      plan.push_back(V_TEST);
      plan.push_back(V_ERR);
    end else begin
      k = -1;
      for (int i = 0; i < int'(W); i++) if (op[i]) k = i;
      for (int i = 0; i <= k; i++) begin
        plan.push_back(V_TEST);
        if (op[i]) plan.push_back(V_INC);
        plan.push_back(V_SHIFT);
      end
      plan.push_back(V_TEST);
      plan.push_back(V_DONE);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      plan.delete();
      mDone = 1'b0;
      expV  = '0;
    end else if (plan.size() > 0) begin
      expV = plan.pop_front();
      if (plan.size() == 0) mDone = 1'b1;
    end else if (mDone) begin
      if (!bus.start) begin
        mDone = 1'b0;
        expV  = '0;
      end
    end else if (bus.start) begin
      buildPlan(operand, stub);
      expV = plan.pop_front();
    end else begin
      expV = '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checkEn) begin
      vec_t act;
      act = outVec();
      nChecks++;
      if (act !== expV) begin
        nErr++;
        $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, expV);
      end
      nChecks++;
      if (!$onehot0({bus.LoadA, bus.IncB, bus.ShiftR}) ||
          (bus.RstB && !bus.LoadA) || (bus.busy && bus.done)) begin
        nErr++;
        $display("FAIL invariants t=%0t actual=%b required=exclusive controls", $time, act);
      end
    end
  end

  // ---------------- operation helpers ----------------
  // Called at a negedge. Raises start, optionally drops it for two cycles
  // from cycle glitchAt (0 = never), returns when done is seen.
  task automatic runOp(input string name, input logic [15:0] op, input logic stuck,
                       input int expCycle, input int glitchAt,
                       output int nInc, output int nShift, output int nTest);
    int cyc;
    int doneCyc;
    operand   = op;
    stub      = stuck;
    bus.start = 1'b1;
    @(posedge clk);
    cyc = 0; nInc = 0; nShift = 0; nTest = 0; doneCyc = -1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({name, " LoadA@1"}, int'(bus.LoadA), 1);
        check({name, " err@1"}, int'(bus.err), 0);
      end
      if (bus.IncB) nInc++;
      if (bus.ShiftR) nShift++;
      if (bus.busy && !bus.LoadA && !bus.IncB && !bus.ShiftR) nTest++;
      if (bus.done) begin
        doneCyc = cyc;
        break;
      end
      if (glitchAt != 0 && cyc == glitchAt) bus.start = 1'b0;
      if (glitchAt != 0 && cyc == glitchAt + 2) bus.start = 1'b1;
    end
    check({name, " doneCycle"}, doneCyc, expCycle);
  endtask

  task automatic releaseStart(input string name);
    bus.start = 1'b0;
    @(negedge clk);
    check({name, " doneDrop"}, int'(bus.done), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nInc, nShift, nTest;
    reset     = 1'b0;
    bus.start = 1'b0;
    operand   = '0;
    stub      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    check("resetState", int'(outVec()), 0);
    reset = 1'b1;
    @(negedge clk);

    // Zero operand: immediate done, no increments or shifts.
    runOp("op0000", 16'h0000, 1'b0, 3, 0, nInc, nShift, nTest);
    check("op0000 result", int'(regB), 0);
    check("op0000 err", int'(bus.err), 0);
    check("op0000 pulses", nInc + nShift, 0);
    releaseStart("op0000");

    runOp("op0001", 16'h0001, 1'b0, 6, 0, nInc, nShift, nTest);
    check("op0001 result", int'(regB), 1);
    releaseStart("op0001");

    runOp("op8000", 16'h8000, 1'b0, 36, 0, nInc, nShift, nTest);
    check("op8000 result", int'(regB), 1);
    releaseStart("op8000");

    runOp("op8001", 16'h8001, 1'b0, 37, 0, nInc, nShift, nTest);
    check("op8001 shifts", nShift, 16);
    check("op8001 incs", nInc, 2);
    check("op8001 result", int'(regB), 2);
    releaseStart("op8001");

    // start glitched low while busy must not disturb the run.
    runOp("opFFFF", 16'hFFFF, 1'b0, 51, 10, nInc, nShift, nTest);
    check("opFFFF result", int'(regB), 16);
    check("opFFFF incs", nInc, 16);
    repeat (2) @(negedge clk);
    check("opFFFF doneHeld", int'(bus.done), 1);
    releaseStart("opFFFF");

    // Stuck datapath: watchdog trips after WIDTH+1 tests.
    runOp("stuck", 16'h0000, 1'b1, 35, 0, nInc, nShift, nTest);
    check("stuck tests", nTest, 17);
    check("stuck err", int'(bus.err), 1);
    releaseStart("stuck");
    runOp("afterErr", 16'h0000, 1'b0, 3, 0, nInc, nShift, nTest);
    check("afterErr err", int'(bus.err), 0);
    releaseStart("afterErr");

    // Reset mid-operation.
    operand   = 16'hFFFF;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("midReset outputs", int'(outVec()), 0);
    reset = 1'b1;
    @(negedge clk);
    runOp("op0003", 16'h0003, 1'b0, 9, 0, nInc, nShift, nTest);
    check("op0003 result", int'(regB), 2);
    releaseStart("op0003");

    // Randomized operands, glitches and hold times.
    for (int n = 0; n < 24; n++) begin
      logic [15:0] op;
      int k, p, ec, g;
      op = 16'($urandom);
      if (n % 4 == 1) op = op & 16'h00FF;
      if (n % 6 == 2) op = 16'h0000;
      k = -1; p = 0;
      for (int i = 0; i < int'(W); i++) if (op[i]) begin k = i; p++; end
      ec = 3 + 2 * (k + 1) + p;
      g = (ec >= 5 && $urandom_range(1, 0) == 1) ? int'($urandom_range(ec - 3, 2)) : 0;
      runOp("rand", op, 1'b0, ec, g, nInc, nShift, nTest);
      check("rand result", int'(regB), p);
      check("rand shifts", nShift, k + 1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      releaseStart("rand");
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErr);
    $finish;
  end

endmodule
